// File: rtl/dco_pkg.sv
// rtl/dco_pkg.sv - shared widths, defaults and clamp helper for the fractional DCO
package dco_pkg;

   localparam int DCO_CTRL_W = 17;
   localparam int DCO_FRAC_W = 4;

   function automatic int dco_cnt_w(input int thr_max);
      return $clog2(thr_max + 2);
   endfunction

   function automatic int dco_raw_w(input int ctrl_w, input int cnt_w, input int frac_w);
      int wide;
      wide = cnt_w + frac_w;
      return ((ctrl_w > wide) ? ctrl_w : wide) + 2;
   endfunction

   function automatic logic signed [63:0] dco_clamp(
      input  logic signed [63:0] raw,
      input  logic signed [63:0] lo,
      input  logic signed [63:0] hi,
      output logic               sat
   );
      if (raw < lo) begin
         sat = 1'b1;
         return lo;
      end else if (raw > hi) begin
         sat = 1'b1;
         return hi;
      end
      sat = 1'b0;
      return raw;
   endfunction

endpackage

// File: rtl/sd_frac_accum.sv
// rtl/sd_frac_accum.sv - first-order sigma-delta: carry is the overflow of acc+frac
module sd_frac_accum #(
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic [FRAC_W-1:0] frac,
   output logic              carry
);

   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [FRAC_W:0]   sum;

   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, frac};
      carry = sum[FRAC_W];
      acc_d = step ? sum[FRAC_W-1:0] : acc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/dco_frac.sv
// rtl/dco_frac.sv - counter-threshold DCO with clamped, dithered fractional half-period
module dco_frac
   import dco_pkg::*;
#(
   parameter int CTRL_W         = DCO_CTRL_W,
   parameter int FRAC_W         = DCO_FRAC_W,
   parameter int BASE_THRESHOLD = 2500,
   parameter int THRESHOLD_MIN  = 10,
   parameter int THRESHOLD_MAX  = 4990
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  en,
   input  logic signed [CTRL_W-1:0]              ctrl_signed,
   output logic                                  dco_out,
   output logic                                  dco_edge,
   output logic                                  dco_rise,
   output logic                                  sat,
   output logic [dco_cnt_w(THRESHOLD_MAX)-1:0]   thr_applied
);

   localparam int CNT_W = dco_cnt_w(THRESHOLD_MAX);
   localparam int RAW_W = dco_raw_w(CTRL_W, CNT_W, FRAC_W);

   localparam logic signed [RAW_W-1:0] BASE_SC = RAW_W'(BASE_THRESHOLD) <<< FRAC_W;
   localparam logic signed [RAW_W-1:0] MIN_SC  = RAW_W'(THRESHOLD_MIN) <<< FRAC_W;
   localparam logic signed [RAW_W-1:0] MAX_SC  = RAW_W'(THRESHOLD_MAX) <<< FRAC_W;
   localparam logic [RAW_W-1:0]        THR_MAX_W = RAW_W'(THRESHOLD_MAX);
   localparam logic [CNT_W-1:0]        THR_RST = CNT_W'(
      (BASE_THRESHOLD < THRESHOLD_MIN) ? THRESHOLD_MIN :
      (BASE_THRESHOLD > THRESHOLD_MAX) ? THRESHOLD_MAX : BASE_THRESHOLD);

   logic [CNT_W-1:0]        count_q, count_d;
   logic [CNT_W-1:0]        thr_q, thr_d;
   logic                    dco_q, dco_d;
   logic                    edge_q, edge_d;
   logic                    rise_q, rise_d;
   logic                    sat_q, sat_d;
   logic signed [RAW_W-1:0] raw, clamped;
   logic [RAW_W-1:0]        thr_int, thr_sum;
   logic                    sat_next, toggle, carry;

   always_comb begin
      raw      = BASE_SC - RAW_W'(ctrl_signed);
      sat_next = 1'b0;
      clamped  = RAW_W'(dco_clamp(64'(raw), 64'(MIN_SC), 64'(MAX_SC), sat_next));
      thr_int  = clamped >>> FRAC_W;
      thr_sum  = thr_int + RAW_W'(carry);
      toggle   = en && (count_q == thr_q);

      count_d = count_q;
      thr_d   = thr_q;
      dco_d   = dco_q;
      sat_d   = sat_q;
      if (en) begin
         sat_d = sat_next;
         if (toggle) begin
            count_d = '0;
            dco_d   = ~dco_q;
            // A dither carry on top of a MAX-clamped integer must not exceed MAX
            thr_d   = (thr_sum > THR_MAX_W) ? CNT_W'(THRESHOLD_MAX) : thr_sum[CNT_W-1:0];
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
      edge_d = toggle;
      rise_d = toggle && !dco_q;
   end

   generate
      if (FRAC_W > 0) begin : g_frac
         logic [FRAC_W-1:0] frac;
         assign frac = clamped[FRAC_W-1:0];
         sd_frac_accum #(.FRAC_W(FRAC_W)) u_accum (
            .clk   (clk),
            .rst   (rst),
            .step  (toggle),
            .frac  (frac),
            .carry (carry)
         );
      end else begin : g_int
         assign carry = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         thr_q   <= THR_RST;
         dco_q   <= 1'b0;
         edge_q  <= 1'b0;
         rise_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         thr_q   <= thr_d;
         dco_q   <= dco_d;
         edge_q  <= edge_d;
         rise_q  <= rise_d;
         sat_q   <= sat_d;
      end
   end

   assign dco_out     = dco_q;
   assign dco_edge    = edge_q;
   assign dco_rise    = rise_q;
   assign sat         = sat_q;
   assign thr_applied = thr_q;

endmodule

// File: tb/tb_dco_frac.sv
// tb/tb_dco_frac.sv - bench for dco_frac: half-period model plus directed timing checks
module tb_dco_frac;

   localparam int CTRL_W = 17;
   localparam int FRAC_W = 4;
   localparam int BASE   = 4;
   localparam int TMIN   = 2;
   localparam int TMAX   = 12;
   localparam int CNT_W  = 4;
   localparam int ONE    = 1 << FRAC_W;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     en  = 1'b0;
   logic signed [CTRL_W-1:0] ctrl = '0;
   logic                     dco_out, dco_edge, dco_rise, sat;
   logic [CNT_W-1:0]         thr_applied;

   int tests = 0;
   int fails = 0;

   dco_frac #(
      .CTRL_W(CTRL_W), .FRAC_W(FRAC_W), .BASE_THRESHOLD(BASE),
      .THRESHOLD_MIN(TMIN), .THRESHOLD_MAX(TMAX)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .ctrl_signed(ctrl),
      .dco_out(dco_out), .dco_edge(dco_edge), .dco_rise(dco_rise),
      .sat(sat), .thr_applied(thr_applied)
   );

   always #5 clk = ~clk;

   // Reference: elapsed enabled cycles in the half-period vs. its length thr+1
   int m_elapsed, m_thr, m_frac_err;
   bit m_dco, m_edge, m_rise, m_sat;

   always @(posedge clk or posedge rst) begin : model
      int raw, sum, whole, fpart;
      bit clipped;
      if (rst) begin
         m_elapsed = 0; m_thr = BASE; m_frac_err = 0;
         m_dco = 0; m_edge = 0; m_rise = 0; m_sat = 0;
      end else begin
         raw = BASE * ONE - int'(ctrl);
         clipped = 0;
         if (raw < TMIN * ONE) begin raw = TMIN * ONE; clipped = 1; end
         else if (raw > TMAX * ONE) begin raw = TMAX * ONE; clipped = 1; end
         whole = raw / ONE;
         fpart = raw % ONE;
         m_edge = 0;
         m_rise = 0;
         if (en) begin
            m_sat = clipped;
            m_elapsed++;
            if (m_elapsed == m_thr + 1) begin
               m_elapsed = 0;
               m_edge = 1;
               m_rise = !m_dco;
               m_dco = !m_dco;
               sum = m_frac_err + fpart;
               m_frac_err = sum % ONE;
               m_thr = whole + sum / ONE;
               if (m_thr > TMAX) m_thr = TMAX;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         tests++;
         if ({dco_out, dco_edge, dco_rise, sat, thr_applied} !==
             {m_dco, m_edge, m_rise, m_sat, 4'(m_thr)}) begin
            fails++;
            $display("FAIL model_cycle t=%0t out/edge/rise/sat/thr got %b%b%b%b/%0d want %b%b%b%b/%0d",
                     $time, dco_out, dco_edge, dco_rise, sat, thr_applied,
                     m_dco, m_edge, m_rise, m_sat, m_thr);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Counts negedges until the next dco_edge pulse; that count equals the half-period
   task automatic wait_edge(input int start, output int n);
      n = start;
      do begin
         @(negedge clk);
         n++;
      end while (!dco_edge && n < 200);
      if (!dco_edge) begin
         tests++;
         fails++;
         $display("FAIL edge_timeout: got no edge after %0d cycles want edge", n);
      end
   endtask

   initial begin : stim
      int n, sum;
      rst = 1'b1; en = 1'b1; ctrl = '0;
      repeat (3) @(negedge clk);
      chk("rst_dco", int'(dco_out), 0);
      chk("rst_edge", int'(dco_edge), 0);
      chk("rst_sat", int'(sat), 0);
      chk("rst_thr", int'(thr_applied), 4);
      rst = 1'b0;

      wait_edge(0, n);
      chk("nom_first_hp", n, 5);
      chk("nom_first_rise", int'(dco_rise), 1);
      for (int i = 0; i < 4; i++) begin
         wait_edge(0, n);
         chk("nom_hp", n, 5);
         chk("nom_rise", int'(dco_rise), (i % 2 == 0) ? 0 : 1);
         chk("nom_sat", int'(sat), 0);
      end

      ctrl = -17'sd8;
      wait_edge(0, n);
      chk("frac_transition_hp", n, 5);
      sum = 0;
      for (int i = 0; i < 16; i++) begin
         wait_edge(0, n);
         sum += n;
         chk("frac_hp", n, (i % 2 == 0) ? 5 : 6);
      end
      chk("frac_sum16", sum, 88);

      ctrl = 17'sd160;
      wait_edge(0, n);
      chk("clamp_lo_thr", int'(thr_applied), 2);
      chk("clamp_lo_sat", int'(sat), 1);
      wait_edge(0, n);
      chk("clamp_lo_hp", n, 3);

      ctrl = -17'sd320;
      wait_edge(0, n);
      chk("clamp_hi_thr", int'(thr_applied), 12);
      chk("clamp_hi_sat", int'(sat), 1);
      wait_edge(0, n);
      chk("clamp_hi_hp", n, 13);

      ctrl = '0;
      @(negedge clk);
      chk("unclamp_sat", int'(sat), 0);
      wait_edge(1, n);
      chk("unclamp_cur_hp", n, 13);
      chk("unclamp_thr", int'(thr_applied), 4);
      wait_edge(0, n);
      chk("unclamp_hp", n, 5);

      repeat (2) @(negedge clk);
      ctrl = -17'sd64;
      wait_edge(2, n);
      chk("glitch_cur_hp", n, 5);
      chk("glitch_thr", int'(thr_applied), 8);
      wait_edge(0, n);
      chk("glitch_next_hp", n, 9);

      ctrl = '0;
      wait_edge(0, n);
      chk("en_pre_hp", n, 9);
      repeat (2) @(negedge clk);
      en = 1'b0;
      repeat (7) @(negedge clk);
      en = 1'b1;
      wait_edge(9, n);
      chk("en_stall_hp", n, 12);

      ctrl = -17'sd8;
      wait_edge(0, n);
      wait_edge(0, n);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_dco", int'(dco_out), 0);
      chk("arst_edge", int'(dco_edge), 0);
      chk("arst_rise", int'(dco_rise), 0);
      chk("arst_sat", int'(sat), 0);
      chk("arst_thr", int'(thr_applied), 4);
      @(negedge clk);
      rst = 1'b0;
      wait_edge(0, n);
      chk("arst_hp1", n, 5);
      wait_edge(0, n);
      chk("arst_hp2", n, 5);
      wait_edge(0, n);
      chk("arst_hp3", n, 6);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 29) == 0)
            ctrl = CTRL_W'(int'($urandom_range(0, 300)) - 200);
         if ($urandom_range(0, 999) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      fails++;
      $display("FAIL watchdog: got timeout want completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dco_frac.md
Name: dco_frac

Overview:
- Next-generation counter-threshold DCO for the ADPLL.
- Takes a signed fixed-point control word (integer + FRAC_W fractional bits) from the loop filter and sets the half-period length as BASE_THRESHOLD minus the control word, clamped to a legal range.
- Resolves fractional thresholds with first-order sigma-delta dithering of the integer threshold.
- Latches a new threshold only at toggle instants, so the output is glitch-free. Also provides enable, edge strobes and a saturation flag for loop monitoring.

Parameters:
- CTRL_W, 17: width of signed control word, two's complement.
- FRAC_W, 4: fractional bits in control word (0 = integer-only mode, dither disabled).
- BASE_THRESHOLD, 2500: nominal integer half-period threshold at ctrl=0.
- THRESHOLD_MIN, 10: lowest applied integer threshold; must be ≥1.
- THRESHOLD_MAX, 4990: highest applied integer threshold.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  count enable; 0 freezes the oscillator
- ctrl_signed  in  CTRL_W  signed control word, FRAC_W fractional bits
- dco_out  out  1  DCO square-wave output (registered)
- dco_edge  out  1  one-cycle pulse in the cycle after any dco_out toggle
- dco_rise  out  1  one-cycle pulse in the cycle after a 0→1 toggle
- sat  out  1  registered; 1 when the last sampled raw threshold was clamped
- thr_applied  out  CNT_W  integer threshold governing the current half-period

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous, active-high.
- Widths:
  - CNT_W = $clog2(THRESHOLD_MAX+2).
  - RAW_W = max(CTRL_W, CNT_W+FRAC_W)+2.
  - All arithmetic is signed at RAW_W after sign extension.
- Raw threshold: raw = (BASE_THRESHOLD<<FRAC_W) − ctrl_signed.
- Clamp:
  - raw < (MIN<<FRAC_W) → (MIN<<FRAC_W), sat_next=1.
  - raw > (MAX<<FRAC_W) → (MAX<<FRAC_W), sat_next=1.
  - Otherwise raw, sat_next=0.
  - Split the clamped value into I (integer) and F (FRAC_W bits).
- Counter: count increments each enabled cycle. When count == thr_applied, in the same edge:
  - count←0 and dco_out toggles.
  - Half-period = thr_applied+1 enabled cycles.
- Threshold update, only on a toggle cycle:
  - acc_next = acc + F; carry c = overflow out of FRAC_W bits.
  - thr_applied ← I + c, saturated to THRESHOLD_MAX; acc ← acc_next.
  - ctrl_signed is sampled in the toggle cycle only. Changes mid-half-period have no effect until the next toggle.
- sat updates every enabled cycle from the current ctrl_signed.
- Strobes: dco_edge and dco_rise are registered and asserted in the cycle after the toggle edge, high for exactly 1 cycle.
- en=0:
  - count, dco_out, acc, thr_applied and sat hold.
  - Strobes are forced 0.
  - Resumes exactly where it stopped when en returns to 1.
- Reset values:
  - count=0, dco_out=0, dco_edge=0, dco_rise=0, sat=0, acc=0.
  - thr_applied = BASE_THRESHOLD clamped to [MIN, MAX].
  - Reset mid-half-period aborts it immediately. The first half-period after reset uses BASE.
- No overflow: count never exceeds THRESHOLD_MAX, so count cannot wrap.
- FRAC_W=0: the accumulator is removed, c=0, and behaviour reduces to an integer threshold latched at toggles.
- Long-run average half-period = clamped raw/2^FRAC_W + 1 cycles, exact over 2^FRAC_W half-periods for constant ctrl.

Decomposition:
- Package dco_pkg holds:
  - width helper function (CNT_W, RAW_W derivation);
  - clamp function (raw, min, max → value, sat);
  - localparam defaults shared with the loop filter (CTRL_W, FRAC_W).
- Sub-module sd_frac_accum (FRAC_W-bit first-order sigma-delta):
  - Inputs: clk, rst, step (advance strobe), frac.
  - Output: carry.
  - Reusable by future fractional dividers.

Test Plan:
- Nominal: test parameters BASE=4, MIN=2, MAX=12, FRAC_W=4, ctrl=0 → dco_out toggles every 5 cycles, period 10; dco_edge every 5 cycles, dco_rise every 10; sat=0.
- Fractional: ctrl = −8 (−0.5) → raw 4.5 → half-periods alternate 5, 6, 5, 6 (thr_applied 4, 5); average over 16 half-periods = 5.5 cycles exactly.
- Clamp:
  - ctrl=+160 (+10.0) → thr_applied=2, half-period 3, sat=1.
  - ctrl=−320 → thr_applied=12, half-period 13, sat=1.
  - Returning to ctrl=0 → sat=0 next cycle, and the next toggle restores thr_applied=4.
- Glitch-free update: change ctrl from 0 to −64 two cycles after a toggle → current half-period still 5 cycles, next half-period 9 cycles.
- Enable: deassert en for 7 cycles mid-half-period → dco_out, count and strobes frozen; total half-period = 5 enabled cycles + 7 stalled cycles = 12 clocks.
- Reset: assert rst asynchronously mid-half-period with ctrl=−8 → all outputs reset immediately and thr_applied=4; after release the first half-period is 5 cycles and acc restarts from 0.
